// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM copy engine, the RAM and the port mux.
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy engine mastering the single-port data RAM: one read then one write per word,
// ascending order, 2 cycles per word, a single-cycle done pulse after the last write.
module mem_copy_dma
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] src_ptr_q;
  logic [ADDR_WIDTH-1:0] dst_ptr_q;
  logic [ADDR_WIDTH-1:0] remaining_q;
  logic                  busy_q;
  logic                  done_q;

  // Control FSM with pointers, word counter and registered busy/done flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      // Abort beats everything, including a start in the same cycle.
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            src_ptr_q   <= src_addr;
            dst_ptr_q   <= dst_addr;
            remaining_q <= length;
            if (length != '0) begin
              state_q <= StRd;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRd: begin
          state_q <= StWr;
        end
        StWr: begin
          src_ptr_q   <= src_ptr_q + ADDR_WIDTH'(1);
          dst_ptr_q   <= dst_ptr_q + ADDR_WIDTH'(1);
          remaining_q <= remaining_q - ADDR_WIDTH'(1);
          if (remaining_q != ADDR_WIDTH'(1)) begin
            state_q <= StRd;
          end else begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // RAM port decode; write data is the RAM output of the preceding read cycle.
  always_comb begin
    mem_address = src_ptr_q;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (state_q == StWr) begin
      mem_address = dst_ptr_q;
      mem_data    = mem_q;
      mem_wren    = !abort;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed self-checking bench for mem_copy_dma with a behavioural registered-address RAM.
module tb_mem_copy_dma;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] mem_q;

  logic [15:0] ram [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [15:0] bd_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_copy_dma #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single-port RAM, registered read address, plus a backdoor write port for preloading.
  always @(posedge clock) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wren) ram[mem_address] <= mem_data;
    mem_q <= ram[mem_address];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    bd_addr = a;
    bd_data = v;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  // Start a copy in the current cycle (cycle 0) and check every cycle against the
  // cycle-exact schedule. pulse_at != 0 re-pulses start with other operands mid-copy.
  task automatic copy(input logic [15:0] s, input logic [15:0] d, input int l,
                      input int pulse_at, input bit stop_at_done);
    int          last;
    logic [15:0] ea;
    last     = stop_at_done ? 2 * l + 1 : 2 * l + 2;
    src_addr = s;
    dst_addr = d;
    length   = 16'(l);
    start    = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      check("busy", busy, (c >= 1 && c <= 2 * l));
      check("done", done, (c == 2 * l + 1));
      check("wren", mem_wren, (c >= 2 && c <= 2 * l && c % 2 == 0));
      if (c <= 2 * l) begin
        if (c % 2 == 1) ea = 16'(s + 16'((c - 1) / 2));
        else ea = 16'(d + 16'((c - 2) / 2));
        check("addr", mem_address, ea);
      end
      if (pulse_at != 0 && c == pulse_at) begin
        start    = 1'b1;
        src_addr = 16'h5000;
        dst_addr = 16'h5100;
        length   = 16'd1;
      end
      if (pulse_at != 0 && c == pulse_at + 1) start = 1'b0;
    end
  endtask

  initial begin
    int wr;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_data  = '0;
    reset_n  = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    src_addr = 16'h0010;
    dst_addr = 16'h0100;
    length   = 16'd4;

    // Reset holds everything at zero even with start asserted.
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Basic 4-word copy.
    poke(16'h0010, 16'h00A1);
    poke(16'h0011, 16'h00B2);
    poke(16'h0012, 16'h00C3);
    poke(16'h0013, 16'h00D4);
    copy(16'h0010, 16'h0100, 4, 0, 1'b0);
    check("basic0", ram[16'h0100], 16'h00A1);
    check("basic1", ram[16'h0101], 16'h00B2);
    check("basic2", ram[16'h0102], 16'h00C3);
    check("basic3", ram[16'h0103], 16'h00D4);

    // Zero length: done in cycle 1, never busy, no writes.
    copy(16'h0010, 16'h0100, 0, 0, 1'b0);

    // Address wrap across 0xFFFF.
    poke(16'hFFFE, 16'h1111);
    poke(16'hFFFF, 16'h2222);
    poke(16'h0000, 16'h3333);
    copy(16'hFFFE, 16'h0200, 3, 0, 1'b0);
    check("wrap0", ram[16'h0200], 16'h1111);
    check("wrap1", ram[16'h0201], 16'h2222);
    check("wrap2", ram[16'h0202], 16'h3333);

    // Overlap dst = src + 1 replicates the first word.
    poke(16'h0020, 16'h5555);
    poke(16'h0021, 16'h0000);
    poke(16'h0022, 16'h0000);
    poke(16'h0023, 16'h0000);
    copy(16'h0020, 16'h0021, 3, 0, 1'b0);
    check("ovl1", ram[16'h0021], 16'h5555);
    check("ovl2", ram[16'h0022], 16'h5555);
    check("ovl3", ram[16'h0023], 16'h5555);

    // Abort in cycle 5 (a read cycle) of an 8-word copy.
    for (int i = 0; i < 8; i++) poke(16'(16'h0040 + i), 16'(16'h4000 + i));
    poke(16'h0082, 16'h0000);
    poke(16'h00A0, 16'h0000);
    src_addr = 16'h0040;
    dst_addr = 16'h0080;
    length   = 16'd8;
    start    = 1'b1;
    wr       = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      abort = (c == 5);
      #1;
      if (mem_wren) wr++;
      if (c == 5) begin
        check("abrt_wren", mem_wren, 0);
        check("abrt_busy5", busy, 1);
      end
      if (c == 6) begin
        check("abrt_busy6", busy, 0);
        check("abrt_addr6", mem_address, 16'h0042);
      end
      if (c >= 6) check("abrt_done", done, 0);
    end
    check("abrt_words", wr, 2);
    check("abrt_m0", ram[16'h0080], 16'h4000);
    check("abrt_m1", ram[16'h0081], 16'h4001);
    check("abrt_m2", ram[16'h0082], 16'h0000);

    // Abort during a write cycle suppresses that write.
    src_addr = 16'h0040;
    dst_addr = 16'h00A0;
    length   = 16'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abwr_pre", mem_wren, 1);
    abort = 1'b1;
    #1;
    check("abwr_wren", mem_wren, 0);
    tick();
    abort = 1'b0;
    check("abwr_busy", busy, 0);
    check("abwr_mem", ram[16'h00A0], 16'h0000);

    // Abort and start together: start dropped.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abst_busy", busy, 0);
    check("abst_done", done, 0);

    // A normal copy after abort.
    copy(16'h0040, 16'h0090, 2, 0, 1'b0);
    check("post0", ram[16'h0090], 16'h4000);
    check("post1", ram[16'h0091], 16'h4001);

    // Start pulsed mid-copy is ignored.
    copy(16'h0010, 16'h0300, 4, 3, 1'b0);
    check("ign0", ram[16'h0300], 16'h00A1);
    check("ign3", ram[16'h0303], 16'h00D4);

    // Back-to-back: second start accepted in the DONE cycle of the first.
    copy(16'h0010, 16'h0400, 2, 0, 1'b1);
    copy(16'h0012, 16'h0410, 2, 0, 1'b0);
    check("b2b0", ram[16'h0400], 16'h00A1);
    check("b2b1", ram[16'h0401], 16'h00B2);
    check("b2b2", ram[16'h0410], 16'h00C3);
    check("b2b3", ram[16'h0411], 16'h00D4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
